// File: rtl/jtag_tap_sync_if.sv
`default_nettype none
// =============================================================================
// Module   : jtag_tap_sync_if
// Purpose  : User DR port between the TAP and a downstream debug-module stage.
// Revision : 1.0
// =============================================================================
interface jtag_tap_sync_if;
    logic user_capture;
    logic user_shift;
    logic user_update;
    logic user_tdi;
    logic user_tdo;

    modport master (
        output user_capture,
        output user_shift,
        output user_update,
        output user_tdi,
        input  user_tdo
    );

    modport slave (
        input  user_capture,
        input  user_shift,
        input  user_update,
        input  user_tdi,
        output user_tdo
    );
endinterface
`default_nettype wire

// File: rtl/jtag_tap_sync.sv
`default_nettype none
// =============================================================================
// Module   : jtag_tap_sync
// Purpose  : clk-domain IEEE 1149.1 TAP (IDCODE, BYPASS, one user DR) driven
//            by oversampled JTAG pins.
// Revision : 1.0
// =============================================================================
module jtag_tap_sync #(
    parameter int                  IR_WIDTH     = 5,
    parameter logic [31:0]         IDCODE_VALUE = 32'hDEB1_1001,
    parameter logic [IR_WIDTH-1:0] IR_IDCODE    = IR_WIDTH'(5'h01),
    parameter logic [IR_WIDTH-1:0] IR_USER      = IR_WIDTH'(5'h11),
    parameter int                  SYNC_STAGES  = 2
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                tck,
    input  wire logic                tms,
    input  wire logic                tdi,
    input  wire logic                trst_n,
    output logic                     tdo,
    output logic                     tdo_en,
    output logic [3:0]               tap_state,
    output logic [IR_WIDTH-1:0]      ir_out,
    jtag_tap_sync_if.master          user
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers and TCK edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_tck_sync;
    logic [SYNC_STAGES-1:0] r_tms_sync;
    logic [SYNC_STAGES-1:0] r_tdi_sync;
    logic [SYNC_STAGES-1:0] r_trst_sync;
    logic                   r_tck_d;

    logic w_tck_s;
    logic w_tms_s;
    logic w_tdi_s;
    logic w_trst_n_s;
    logic w_tck_rise;
    logic w_tck_fall;
    logic w_rise_ok;

    // tms starts high and trst_n low so the FSM sits in TLR until the pins settle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tck_sync  <= '0;
            r_tms_sync  <= '1;
            r_tdi_sync  <= '0;
            r_trst_sync <= '0;
            r_tck_d     <= 1'b0;
        end else begin
            r_tck_sync  <= {r_tck_sync[SYNC_STAGES-2:0], tck};
            r_tms_sync  <= {r_tms_sync[SYNC_STAGES-2:0], tms};
            r_tdi_sync  <= {r_tdi_sync[SYNC_STAGES-2:0], tdi};
            r_trst_sync <= {r_trst_sync[SYNC_STAGES-2:0], trst_n};
            r_tck_d     <= w_tck_s;
        end
    end

    assign w_tck_s    = r_tck_sync[SYNC_STAGES-1];
    assign w_tms_s    = r_tms_sync[SYNC_STAGES-1];
    assign w_tdi_s    = r_tdi_sync[SYNC_STAGES-1];
    assign w_trst_n_s = r_trst_sync[SYNC_STAGES-1];
    assign w_tck_rise = w_tck_s & ~r_tck_d;
    assign w_tck_fall = ~w_tck_s & r_tck_d;
    assign w_rise_ok  = w_tck_rise & w_trst_n_s;

    // ------------------------------------------------------------------
    // TAP state machine
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TLR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_trst_n_s) begin
            w_state_nxt = TLR;
        end else if (w_tck_rise) begin
            case (r_state)
                TLR:     w_state_nxt = w_tms_s ? TLR    : RTI;
                RTI:     w_state_nxt = w_tms_s ? SEL_DR : RTI;
                SEL_DR:  w_state_nxt = w_tms_s ? SEL_IR : CAP_DR;
                CAP_DR:  w_state_nxt = w_tms_s ? EX1_DR : SH_DR;
                SH_DR:   w_state_nxt = w_tms_s ? EX1_DR : SH_DR;
                EX1_DR:  w_state_nxt = w_tms_s ? UPD_DR : PAU_DR;
                PAU_DR:  w_state_nxt = w_tms_s ? EX2_DR : PAU_DR;
                EX2_DR:  w_state_nxt = w_tms_s ? UPD_DR : SH_DR;
                UPD_DR:  w_state_nxt = w_tms_s ? SEL_DR : RTI;
                SEL_IR:  w_state_nxt = w_tms_s ? TLR    : CAP_IR;
                CAP_IR:  w_state_nxt = w_tms_s ? EX1_IR : SH_IR;
                SH_IR:   w_state_nxt = w_tms_s ? EX1_IR : SH_IR;
                EX1_IR:  w_state_nxt = w_tms_s ? UPD_IR : PAU_IR;
                PAU_IR:  w_state_nxt = w_tms_s ? EX2_IR : PAU_IR;
                EX2_IR:  w_state_nxt = w_tms_s ? UPD_IR : SH_IR;
                UPD_IR:  w_state_nxt = w_tms_s ? SEL_DR : RTI;
                default: w_state_nxt = TLR;
            endcase
        end
    end

    assign tap_state = r_state;

    // ------------------------------------------------------------------
    // Instruction register
    // ------------------------------------------------------------------
    logic [IR_WIDTH-1:0] r_ir_sr;
    logic [IR_WIDTH-1:0] r_ir_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir_sr <= '0;
        end else if (w_rise_ok) begin
            if (r_state == CAP_IR) begin
                r_ir_sr <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
            end else if (r_state == SH_IR) begin
                r_ir_sr <= {w_tdi_s, r_ir_sr[IR_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir_out <= IR_IDCODE;
        end else if (r_state == TLR) begin
            r_ir_out <= IR_IDCODE;
        end else if (w_tck_fall && (r_state == UPD_IR)) begin
            r_ir_out <= r_ir_sr;
        end
    end

    assign ir_out = r_ir_out;

    // ------------------------------------------------------------------
    // Data registers: IDCODE and BYPASS live here, the user DR lives outside
    // ------------------------------------------------------------------
    logic        w_sel_id;
    logic        w_sel_user;
    logic [31:0] r_id_sr;
    logic        r_bypass;
    logic        w_dr_lsb;

    assign w_sel_id   = (r_ir_out == IR_IDCODE);
    assign w_sel_user = (r_ir_out == IR_USER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_sr  <= '0;
            r_bypass <= 1'b0;
        end else if (w_rise_ok) begin
            if (r_state == CAP_DR) begin
                if (w_sel_id) begin
                    r_id_sr <= IDCODE_VALUE;
                end else if (!w_sel_user) begin
                    r_bypass <= 1'b0;
                end
            end else if (r_state == SH_DR) begin
                if (w_sel_id) begin
                    r_id_sr <= {w_tdi_s, r_id_sr[31:1]};
                end else if (!w_sel_user) begin
                    r_bypass <= w_tdi_s;
                end
            end
        end
    end

    assign w_dr_lsb = w_sel_id   ? r_id_sr[0]    :
                      w_sel_user ? user.user_tdo :
                                   r_bypass;

    // ------------------------------------------------------------------
    // TDO launch on the falling TCK edge
    // ------------------------------------------------------------------
    logic r_tdo;
    logic r_tdo_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else if (w_tck_fall) begin
            case (r_state)
                SH_IR: begin
                    r_tdo_en <= 1'b1;
                    r_tdo    <= r_ir_sr[0];
                end
                SH_DR: begin
                    r_tdo_en <= 1'b1;
                    r_tdo    <= w_dr_lsb;
                end
                default: begin
                    r_tdo_en <= 1'b0;
                    r_tdo    <= 1'b0;
                end
            endcase
        end
    end

    assign tdo    = r_tdo;
    assign tdo_en = r_tdo_en;

    // ------------------------------------------------------------------
    // User DR strobes
    // ------------------------------------------------------------------
    logic r_user_capture;
    logic r_user_shift;
    logic r_user_update;
    logic r_user_tdi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_user_capture <= 1'b0;
            r_user_shift   <= 1'b0;
            r_user_update  <= 1'b0;
            r_user_tdi     <= 1'b0;
        end else begin
            r_user_capture <= w_rise_ok && w_sel_user && (r_state == CAP_DR);
            r_user_shift   <= w_rise_ok && w_sel_user && (r_state == SH_DR);
            r_user_update  <= w_tck_fall && w_trst_n_s && w_sel_user && (r_state == UPD_DR);
            if (w_rise_ok && w_sel_user && (r_state == SH_DR)) begin
                r_user_tdi <= w_tdi_s;
            end
        end
    end

    assign user.user_capture = r_user_capture;
    assign user.user_shift   = r_user_shift;
    assign user.user_update  = r_user_update;
    assign user.user_tdi     = r_user_tdi;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_sync.sv
`default_nettype none
// =============================================================================
// Module   : tb_jtag_tap_sync
// Purpose  : Scoreboard bench for jtag_tap_sync against a table-driven TAP model.
// Revision : 1.0
// =============================================================================
module tb_jtag_tap_sync;
    localparam int          IRW     = 5;
    localparam int          SYNC    = 2;
    localparam logic [31:0] IDV     = 32'hDEB1_1001;
    localparam logic [4:0]  OP_ID   = 5'h01;
    localparam logic [4:0]  OP_USER = 5'h11;
    localparam int          HALF    = 80;

    // next-state nibble for each state code, indexed by code*4
    localparam logic [63:0] NX0 = 64'hCACC_BABA_62CE_3232;
    localparam logic [63:0] NX1 = 64'hF977_89DD_417F_0155;

    localparam logic [3:0] S_TLR = 4'hF, S_CDR = 4'h6, S_SDR = 4'h2, S_UDR = 4'h5;
    localparam logic [3:0] S_CIR = 4'hE, S_SIR = 4'hA, S_UIR = 4'hD;

    logic clk = 1'b0;
    logic rst, tck, tms, tdi, trst_n;
    logic tdo, tdo_en;
    logic [3:0] tap_state;
    logic [IRW-1:0] ir_out;

    jtag_tap_sync_if uif();

    jtag_tap_sync #(
        .IR_WIDTH(IRW), .IDCODE_VALUE(IDV), .IR_IDCODE(OP_ID),
        .IR_USER(OP_USER), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .trst_n(trst_n),
        .tdo(tdo), .tdo_en(tdo_en), .tap_state(tap_state), .ir_out(ir_out),
        .user(uif)
    );

    always #5 clk = ~clk;

    // downstream user DR: 8-bit register that captures 3C
    logic [7:0] dev_sr;
    always @(posedge clk or posedge rst) begin
        if (rst)                   dev_sr <= 8'h3C;
        else if (uif.user_capture) dev_sr <= 8'h3C;
        else if (uif.user_shift)   dev_sr <= {uif.user_tdi, dev_sr[7:1]};
    end
    assign uif.user_tdo = dev_sr[0];

    typedef struct {
        logic [3:0]     st;
        logic [IRW-1:0] ir;
        logic           en;
        logic           d;
    } pin_exp_t;
    typedef struct {
        int   kind;
        logic b;
    } ev_t;

    pin_exp_t pin_q[$];
    ev_t      ev_q[$];
    int total = 0;
    int bad   = 0;
    bit mon_on = 0;

    logic [63:0] tlog;
    int          tlog_n = 0;
    int          cnt_cap = 0, cnt_sh = 0, cnt_up = 0;
    logic [7:0]  utdi_log;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0]     m_state;
    logic [IRW-1:0] m_ir;
    int             m_irsr;
    logic [31:0]    m_id;
    logic           m_byp;
    logic [7:0]     m_usr;

    task automatic m_rise(input logic ms, input logic di);
        case (m_state)
            S_CIR: m_irsr = 1;
            S_SIR: m_irsr = (m_irsr >> 1) + (di ? (1 << (IRW-1)) : 0);
            S_CDR: begin
                if (m_ir == OP_ID) m_id = IDV;
                else if (m_ir == OP_USER) begin
                    ev_q.push_back('{0, 1'b0});
                    m_usr = 8'h3C;
                end else m_byp = 1'b0;
            end
            S_SDR: begin
                if (m_ir == OP_ID) m_id = (m_id >> 1) | (di ? 32'h8000_0000 : 32'h0);
                else if (m_ir == OP_USER) begin
                    ev_q.push_back('{1, di});
                    m_usr = (m_usr >> 1) | (di ? 8'h80 : 8'h00);
                end else m_byp = di;
            end
            default: ;
        endcase
        m_state = ms ? NX1[m_state*4 +: 4] : NX0[m_state*4 +: 4];
        if (m_state == S_TLR) m_ir = OP_ID;
    endtask

    task automatic m_fall();
        pin_exp_t e;
        if (m_state == S_UIR) m_ir = m_irsr[IRW-1:0];
        if (m_state == S_UDR && m_ir == OP_USER) ev_q.push_back('{2, 1'b0});
        if (m_state == S_TLR) m_ir = OP_ID;
        e.st = m_state;
        e.ir = m_ir;
        e.en = 1'b0;
        e.d  = 1'b0;
        if (m_state == S_SIR) begin
            e.en = 1'b1;
            e.d  = m_irsr[0];
        end else if (m_state == S_SDR) begin
            e.en = 1'b1;
            e.d  = (m_ir == OP_ID) ? m_id[0] : (m_ir == OP_USER) ? m_usr[0] : m_byp;
        end
        pin_q.push_back(e);
    endtask

    // ---------------- monitors ----------------
    always @(posedge tck) begin
        if (mon_on) begin
            pin_exp_t e;
            if (pin_q.size() == 0) begin
                total++; bad++;
                $display("FAIL pin_queue: got empty expected entry at %0t", $time);
            end else begin
                e = pin_q.pop_front();
                chk("tap_state", 32'(tap_state), 32'(e.st));
                chk("ir_out",    32'(ir_out),    32'(e.ir));
                chk("tdo_en",    32'(tdo_en),    32'(e.en));
                chk("tdo",       32'(tdo),       32'(e.d));
            end
            if (tdo_en && tlog_n < 64) begin
                tlog[tlog_n] = tdo;
                tlog_n++;
            end
        end
    end

    task automatic ev_check(input int kind, input logic b);
        ev_t e;
        if (ev_q.size() == 0) begin
            total++; bad++;
            $display("FAIL strobe_unexpected: got kind %0d expected none at %0t", kind, $time);
        end else begin
            e = ev_q.pop_front();
            chk("strobe_kind", 32'(kind), 32'(e.kind));
            if (kind == 1) chk("user_tdi", 32'(b), 32'(e.b));
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (uif.user_capture) begin cnt_cap++; ev_check(0, 1'b0); end
            if (uif.user_shift) begin
                if (cnt_sh < 8) utdi_log[cnt_sh] = uif.user_tdi;
                cnt_sh++;
                ev_check(1, uif.user_tdi);
            end
            if (uif.user_update) begin cnt_up++; ev_check(2, 1'b0); end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clk_tck(input logic ms, input logic di);
        tms = ms;
        tdi = di;
        #40;
        tck = 1'b1;
        m_rise(ms, di);
        #HALF;
        tck = 1'b0;
        m_fall();
        #40;
    endtask

    task automatic load_ir(input logic [IRW-1:0] op);
        clk_tck(1, 0); clk_tck(1, 0); clk_tck(0, 0); clk_tck(0, 0);
        for (int i = 0; i < IRW; i++) clk_tck(i == IRW-1, op[i]);
        clk_tck(1, 0); clk_tck(0, 0);
    endtask

    task automatic shift_dr(input logic [31:0] v, input int n);
        clk_tck(1, 0); clk_tck(0, 0); clk_tck(0, 0);
        for (int i = 0; i < n; i++) clk_tck(i == n-1, v[i]);
        clk_tck(1, 0); clk_tck(0, 0);
    endtask

    task automatic clear_logs();
        tlog = '0; tlog_n = 0;
        cnt_cap = 0; cnt_sh = 0; cnt_up = 0; utdi_log = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pin_exp_t e;
        int sh_before;
        rst = 1'b1;
        tck = 1'($urandom); tms = 1'($urandom); tdi = 1'($urandom); trst_n = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state",   32'(tap_state), 32'hF);
        chk("reset_ir",      32'(ir_out),    32'(OP_ID));
        chk("reset_tdo",     32'({tdo_en, tdo}), 32'h0);
        chk("reset_strobes", 32'({uif.user_capture, uif.user_shift, uif.user_update, uif.user_tdi}), 32'h0);

        tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        m_state = S_TLR; m_ir = OP_ID; m_irsr = 0; m_id = '0; m_byp = 1'b0; m_usr = 8'h3C;
        pin_q.push_back('{S_TLR, OP_ID, 1'b0, 1'b0});
        mon_on = 1;

        // IDCODE readout
        clear_logs();
        clk_tck(0, 0);
        shift_dr(32'h0, 32);
        chk("idcode_bits", tlog[31:0], IDV);
        chk("idcode_en_count", 32'(tlog_n), 32'd32);

        // TMS=1 x5 from Shift-DR
        clk_tck(1, 0); clk_tck(0, 0); clk_tck(0, 0);
        for (int i = 0; i < 5; i++) clk_tck(1, 0);
        chk("tlr_from_shdr", 32'(tap_state), 32'hF);

        // TMS=1 x5 from Pause-IR
        clk_tck(0, 0); clk_tck(1, 0); clk_tck(1, 0); clk_tck(0, 0);
        clk_tck(0, 0); clk_tck(1, 0); clk_tck(0, 0);
        chk("in_pauir", 32'(tap_state), 32'hB);
        for (int i = 0; i < 5; i++) clk_tck(1, 0);
        chk("tlr_from_pauir", 32'(tap_state), 32'hF);

        // IR capture pattern and BYPASS
        clk_tck(0, 0);
        clear_logs();
        load_ir(5'h1F);
        chk("ir_capture_bits", 32'(tlog[4:0]), 32'h01);
        chk("ir_capture_count", 32'(tlog_n), 32'd5);
        chk("ir_bypass", 32'(ir_out), 32'h1F);
        clear_logs();
        shift_dr(32'b01101, 5);
        chk("bypass_bits", 32'(tlog[4:0]), 32'b11010);

        // user DR
        load_ir(OP_USER);
        chk("ir_user", 32'(ir_out), 32'(OP_USER));
        clear_logs();
        shift_dr(32'hA5, 8);
        repeat (6) @(posedge clk);
        #1;
        chk("user_capture_count", 32'(cnt_cap), 32'd1);
        chk("user_shift_count",   32'(cnt_sh),  32'd8);
        chk("user_update_count",  32'(cnt_up),  32'd1);
        chk("user_tdi_seq",       32'(utdi_log), 32'hA5);
        chk("user_tdo_bits",      32'(tlog[7:0]), 32'h3C);

        // trst_n pulse mid Shift-DR
        clk_tck(1, 0); clk_tck(0, 0); clk_tck(0, 0);
        for (int i = 0; i < 3; i++) clk_tck(0, 1);
        sh_before = cnt_sh;
        trst_n = 1'b0;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        chk("trst_state", 32'(tap_state), 32'hF);
        repeat (2) @(posedge clk);
        #1;
        chk("trst_ir", 32'(ir_out), 32'(OP_ID));
        trst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        e = pin_q.pop_back();
        e.st = S_TLR;
        e.ir = OP_ID;
        pin_q.push_back(e);
        m_state = S_TLR;
        m_ir = OP_ID;
        for (int i = 0; i < 3; i++) clk_tck(1, 1);
        chk("trst_no_shift", 32'(cnt_sh), 32'(sh_before));

        // random walk
        for (int i = 0; i < 400; i++) clk_tck(1'($urandom_range(0, 9) < 4), 1'($urandom));
        repeat (20) @(posedge clk);
        mon_on = 0;
        chk("events_drained", 32'(ev_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
